// File: rtl/sram_wr_ctrl.sv
// Write-side controller for the 8 weight and 8 data SRAM banks.
// Optional macro SRAM_WR_BASE_EN adds per-load base addresses base_w/base_d.
module sram_wr_ctrl #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 10,
  parameter int W_WORDS = 128,
  parameter int D_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef SRAM_WR_BASE_EN
  input  logic [ADDR_W-1:0] base_w,
  input  logic [ADDR_W-1:0] base_d,
`endif
  output logic              in_ready,
  output logic [7:0]        sram_wen_w,
  output logic [ADDR_W-1:0] sram_waddr_w,
  output logic [DATA_W-1:0] sram_wdata_w,
  output logic [7:0]        sram_wen_d,
  output logic [ADDR_W-1:0] sram_waddr_d,
  output logic [DATA_W-1:0] sram_wdata_d,
  output logic              busy,
  output logic              done
);

  // k spans up to 8*2^ADDR_W words, so k>>3 is exactly ADDR_W bits wide
  localparam int K_W = ADDR_W + 3;

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_D, DONE} state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q;
  logic              hs, last_w, last_d, start_ok;
  logic [ADDR_W-1:0] base_w_q, base_d_q;

  logic [7:0]        wen_w_p1, wen_d_p1;
  logic [ADDR_W-1:0] waddr_w_p1, waddr_d_p1;
  logic [DATA_W-1:0] wdata_w_p1, wdata_d_p1;
  logic              done_p1;

  function automatic logic [7:0] bank_sel(input logic [2:0] bank);
    return 8'h01 << bank;
  endfunction

  // Base plus row index; the sum wraps modulo 2^ADDR_W by truncation
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [K_W-1:0]    k);
    return base + k[K_W-1:3];
  endfunction

  assign hs       = in_valid & in_ready;
  assign last_w   = (k_q == K_W'(W_WORDS - 1));
  assign last_d   = (k_q == K_W'(D_WORDS - 1));
  assign start_ok = (state_q == IDLE) & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)          state_d = LOAD_W;
      LOAD_W:  if (hs && last_w)   state_d = LOAD_D;
      LOAD_D:  if (hs && last_d)   state_d = DONE;
      DONE:                        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      LOAD_W, LOAD_D: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
    end else if (state_q == IDLE || state_q == DONE) begin
      k_q <= '0;
    end else if (hs) begin
      k_q <= (state_q == LOAD_W && last_w) ? '0 : k_q + K_W'(1);
    end
  end

`ifdef SRAM_WR_BASE_EN
  // Bases are frozen for the whole sequence once start is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_w_q <= '0;
      base_d_q <= '0;
    end else if (start_ok) begin
      base_w_q <= base_w;
      base_d_q <= base_d;
    end
  end
`else
  assign base_w_q = '0;
  assign base_d_q = '0;
`endif

  // p0 -> p1: accepted word becomes a bank write one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_w_p1   <= '0;
      waddr_w_p1 <= '0;
      wdata_w_p1 <= '0;
      wen_d_p1   <= '0;
      waddr_d_p1 <= '0;
      wdata_d_p1 <= '0;
      done_p1    <= 1'b0;
    end else begin
      wen_w_p1 <= '0;
      wen_d_p1 <= '0;
      done_p1  <= hs && (state_q == LOAD_D) && last_d;
      if (hs && state_q == LOAD_W) begin
        wen_w_p1   <= bank_sel(k_q[2:0]);
        waddr_w_p1 <= word_addr(base_w_q, k_q);
        wdata_w_p1 <= in_data;
      end
      if (hs && state_q == LOAD_D) begin
        wen_d_p1   <= bank_sel(k_q[2:0]);
        waddr_d_p1 <= word_addr(base_d_q, k_q);
        wdata_d_p1 <= in_data;
      end
    end
  end

  assign sram_wen_w   = wen_w_p1;
  assign sram_waddr_w = waddr_w_p1;
  assign sram_wdata_w = wdata_w_p1;
  assign sram_wen_d   = wen_d_p1;
  assign sram_waddr_d = waddr_d_p1;
  assign sram_wdata_d = wdata_d_p1;
  assign done         = done_p1;

endmodule
